gate3_arbiter: RTL and testbench



---
 rtl/gate3_pkg.sv | 22 ++
 rtl/gate3_cells.sv | 46 ++++
 rtl/gate3_unit.sv | 50 +++++
 rtl/gate3_arbiter.sv | 145 ++++++++++++++
 tb/tb_gate3_arbiter.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate3_pkg.sv
// gate3_pkg: shared definitions for the gate3 arbiter slice.
//   OPW          opcode width
//   OP_AND..     legal opcode values (6 and 7 are illegal)
//   state_t      sequencer states IDLE/EVAL/RESP
package gate3_pkg;

   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_AND  = 3'd0;
   localparam logic [OPW-1:0] OP_OR   = 3'd1;
   localparam logic [OPW-1:0] OP_NOR  = 3'd2;
   localparam logic [OPW-1:0] OP_NAND = 3'd3;
   localparam logic [OPW-1:0] OP_XOR  = 3'd4;
   localparam logic [OPW-1:0] OP_XNOR = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/gate3_cells.sv
// Single-bit 3-input gate cells: and3, or3, nor3, nand3, xor3.
// Ports (all cells): a, b, c in 1; y out 1.
module and3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = a & b & c;
endmodule

module or3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = a | b | c;
endmodule

module nor3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = ~(a | b | c);
endmodule

module nand3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = ~(a & b & c);
endmodule

module xor3 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   assign y = a ^ b ^ c;
endmodule

// File: rtl/gate3_unit.sv
// gate3_unit: combinational W-bit 3-input logic unit.
//   op   in  OPW  function select (see gate3_pkg)
//   a,b,c in W    operands
//   y    out W    bitwise result, 0 for illegal op
//   err  out 1    op is illegal
module gate3_unit
   import gate3_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [W-1:0]   c,
   output logic [W-1:0]   y,
   output logic           err
);

   logic [W-1:0] y_and;
   logic [W-1:0] y_or;
   logic [W-1:0] y_nor;
   logic [W-1:0] y_nand;
   logic [W-1:0] y_xor;

   for (genvar i = 0; i < W; i++) begin : g_bit
      and3  u_and3  (.a(a[i]), .b(b[i]), .c(c[i]), .y(y_and[i]));
      or3   u_or3   (.a(a[i]), .b(b[i]), .c(c[i]), .y(y_or[i]));
      nor3  u_nor3  (.a(a[i]), .b(b[i]), .c(c[i]), .y(y_nor[i]));
      nand3 u_nand3 (.a(a[i]), .b(b[i]), .c(c[i]), .y(y_nand[i]));
      xor3  u_xor3  (.a(a[i]), .b(b[i]), .c(c[i]), .y(y_xor[i]));
   end

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_AND:  y = y_and;
         OP_OR:   y = y_or;
         OP_NOR:  y = y_nor;
         OP_NAND: y = y_nand;
         OP_XOR:  y = y_xor;
         OP_XNOR: y = ~y_xor;   // no xnor3 cell; invert the xor3 result
         default: begin
            y   = '0;
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/gate3_arbiter.sv
// gate3_arbiter: round-robin arbiter and sequencer in front of one gate3_unit.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_op                3 bits per requester, requester i at [3i+2:3i]
//   req_a/req_b/req_c     W bits per requester, requester i at [W*i+W-1:W*i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data/rsp_err  owner index, result, illegal-op flag
//   state_dbg             current FSM state (gate3_pkg::state_t encoding)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. Requesters hold valid and payload until
// ready; the response payload holds steady while rsp_valid is high.
module gate3_arbiter
   import gate3_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [OPW*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0]   req_a,
   input  logic [W*NREQ-1:0]   req_b,
   input  logic [W*NREQ-1:0]   req_c,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [W-1:0]        rsp_data,
   output logic                rsp_err,
   output logic [1:0]          state_dbg
);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] win;
   logic           any_valid;
   logic [IDW:0]   idx_w;
   logic [NREQ-1:0] grant_vec;
   logic           grant;

   logic [IDW-1:0] id_q;
   logic [OPW-1:0] op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   c_q;

   logic [W-1:0]   unit_y;
   logic           unit_err;

   // Search upward from ptr with wrap; one extra bit on idx_w so the sum
   // ptr+k cannot overflow before it is folded back below NREQ.
   always_comb begin
      win       = ptr;
      any_valid = 1'b0;
      idx_w     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, ptr} + (IDW+1)'(k);
         if (idx_w >= (IDW+1)'(NREQ)) begin
            idx_w = idx_w - (IDW+1)'(NREQ);
         end
         if (!any_valid && req_valid[idx_w[IDW-1:0]]) begin
            any_valid = 1'b1;
            win       = idx_w[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_vec = '0;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               grant          = 1'b1;
               grant_vec[win] = 1'b1;
               state_nxt      = EVAL;
            end
         end
         EVAL: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ptr_nxt = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;

   // State resets to IDLE asynchronously, but req_ready is combinational from
   // req_valid; gating with rst_n keeps it at zero while reset is held.
   assign req_ready = rst_n ? grant_vec : '0;
   assign rsp_valid = (state == RESP);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         id_q     <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            id_q <= win;
            op_q <= req_op[win*OPW +: OPW];
            a_q  <= req_a[win*W +: W];
            b_q  <= req_b[win*W +: W];
            c_q  <= req_c[win*W +: W];
         end
         if (state == EVAL) begin
            rsp_id   <= id_q;
            rsp_data <= unit_y;
            rsp_err  <= unit_err;
         end
         // Turn order advances only when the response is taken.
         if (state == RESP && rsp_ready) begin
            ptr <= ptr_nxt;
         end
      end
   end

   gate3_unit #(.W(W)) u_unit (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .c   (c_q),
      .y   (unit_y),
      .err (unit_err)
   );

endmodule

// File: tb/tb_gate3_arbiter.sv
module tb_gate3_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a, req_b, req_c;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              rsp_err;
   logic [1:0]        state_dbg;

   logic [2:0]   op_arr[NREQ];
   logic [W-1:0] a_arr[NREQ];
   logic [W-1:0] b_arr[NREQ];
   logic [W-1:0] c_arr[NREQ];

   always_comb begin
      req_op = '0;
      req_a  = '0;
      req_b  = '0;
      req_c  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_op[3*i +: 3] = op_arr[i];
         req_a[W*i +: W]  = a_arr[i];
         req_b[W*i +: W]  = b_arr[i];
         req_c[W*i +: W]  = c_arr[i];
      end
   end

   gate3_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .state_dbg (state_dbg)
   );

   // ---------------- reference model ----------------
   function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] c);
      case (op)
         3'd0:    model = {1'b0, a & b & c};
         3'd1:    model = {1'b0, a | b | c};
         3'd2:    model = {1'b0, ~(a | b | c)};
         3'd3:    model = {1'b0, ~(a & b & c)};
         3'd4:    model = {1'b0, a ^ b ^ c};
         3'd5:    model = {1'b0, ~(a ^ b ^ c)};
         default: model = {1'b1, {W{1'b0}}};
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [IDW+W:0] exp_q[$];   // {id, err, data}
   logic [IDW-1:0] grant_q[$];
   int             grant_cyc_q[$];

   always @(negedge clk) begin
      logic [IDW+W:0] e;
      if (rst_n === 1'b1) begin
         if (req_ready !== '0) begin
            n_checks++;
            if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
               n_errors++;
               $display("FAIL grant_onehot: req_ready=%b req_valid=%b, required one-hot subset of valid",
                        req_ready, req_valid);
            end
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i]) begin
                  grant_q.push_back(IDW'(i));
                  grant_cyc_q.push_back(cyc);
                  exp_q.push_back({IDW'(i), model(op_arr[i], a_arr[i], b_arr[i], c_arr[i])});
               end
            end
         end
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL rsp_unexpected: id=%0d data=%h err=%b, required no response",
                        rsp_id, rsp_data, rsp_err);
            end else begin
               e = exp_q.pop_front();
               if ({rsp_id, rsp_err, rsp_data} !== e) begin
                  n_errors++;
                  $display("FAIL rsp_scoreboard: got id=%0d err=%b data=%h, required id=%0d err=%b data=%h",
                           rsp_id, rsp_err, rsp_data, e[IDW+W:W+1], e[W], e[W-1:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c);
      op_arr[id] = op;
      a_arr[id]  = a;
      b_arr[id]  = b;
      c_arr[id]  = c;
   endtask

   task automatic set_rand(input int id);
      set_req(id, 3'($urandom_range(0, 5)), W'($urandom_range(0, 255)),
              W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
   endtask

   // Returns at the negedge where req_ready[id] is seen.
   task automatic wait_grant(input int id, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready[id] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL grant_timeout: requester %0d got no grant, required a grant", id);
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL rsp_timeout: rsp_valid stayed low, required high");
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && rsp_valid === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, '0, '0, '0);
      rst_n     = 1'b0;
      req_valid = 4'b1011;
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, state_dbg} !== '0) begin
         n_errors++;
         $display("FAIL reset_values: ready=%b valid=%b id=%0d data=%h err=%b state=%0d, required all 0",
                  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, state_dbg);
      end
      tick();
      req_valid = '0;
      rst_n     = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_idle: ready=%b valid=%b state=%0d, required 0 0 0",
                  req_ready, rsp_valid, state_dbg);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[6] = '{0, 1, 2, 3, 0, 1};
      bit got;
      tick();
      for (int i = 0; i < NREQ; i++) set_rand(i);
      grant_q.delete();
      grant_cyc_q.delete();
      req_valid = '1;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (grant_q.size() >= 6) begin
            got = 1'b1;
            break;
         end
      end
      tick();
      req_valid = '0;
      drain();
      n_checks++;
      if (!got) begin
         n_errors++;
         $display("FAIL rr_count: %0d grants, required 6", grant_q.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (grant_q[k] !== IDW'(exp_order[k])) begin
               n_errors++;
               $display("FAIL rr_order[%0d]: granted %0d, required %0d", k, grant_q[k], exp_order[k]);
            end
         end
         for (int k = 1; k < 6; k++) begin
            n_checks++;
            if (grant_cyc_q[k] - grant_cyc_q[k-1] != 3) begin
               n_errors++;
               $display("FAIL rr_spacing[%0d]: %0d cycles, required 3", k,
                        grant_cyc_q[k] - grant_cyc_q[k-1]);
            end
         end
      end
   endtask

   task automatic test_ops();
      logic [W-1:0] lit[6] = '{8'h80, 8'hFE, 8'h01, 8'h7F, 8'h96, 8'h69};
      bit ok;
      for (int op = 0; op < 6; op++) begin
         tick();
         set_req(0, 3'(op), 8'hF0, 8'hCC, 8'hAA);
         req_valid = 4'b0001;
         wait_grant(0, ok);
         if (ok) begin
            tick();                 // handshake edge T has passed
            req_valid = '0;
            @(negedge clk);         // EVAL cycle
            n_checks++;
            if (rsp_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL op%0d_early: rsp_valid=%b after T+1, required 0", op, rsp_valid);
            end
            @(negedge clk);         // RESP cycle, taken at T+2
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== lit[op] || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
               n_errors++;
               $display("FAIL op%0d_result: valid=%b data=%h id=%0d err=%b, required 1 %h 0 0",
                        op, rsp_valid, rsp_data, rsp_id, rsp_err, lit[op]);
            end
         end
         req_valid = '0;
         drain();
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] exp1;
      bit ok;
      tick();
      rsp_ready = 1'b0;
      set_rand(1);
      set_rand(2);
      exp1 = model(op_arr[1], a_arr[1], b_arr[1], c_arr[1]);
      req_valid = 4'b0010;
      wait_grant(1, ok);
      tick();
      req_valid = 4'b0100;
      wait_rsp(ok);
      if (ok) begin
         for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_err, rsp_data} !== exp1 || req_ready !== '0) begin
               n_errors++;
               $display("FAIL stall_hold[%0d]: valid=%b id=%0d err=%b data=%h ready=%b, required 1 1 %b %h 0000",
                        n, rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, exp1[W], exp1[W-1:0]);
            end
         end
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);               // handshake cycle, still RESP
      n_checks++;
      if (req_ready !== '0) begin
         n_errors++;
         $display("FAIL stall_release_ready: req_ready=%b, required 0000", req_ready);
      end
      @(negedge clk);               // cycle after response handshake
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_errors++;
         $display("FAIL stall_next_grant: req_ready=%b, required 0100", req_ready);
      end
      tick();
      req_valid = '0;
      drain();
   endtask

   task automatic test_illegal();
      logic [W:0] exp3;
      bit ok;
      tick();
      set_req(2, 3'd6, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      req_valid = 4'b0100;
      wait_grant(2, ok);
      tick();
      req_valid = '0;
      wait_rsp(ok);
      if (ok) begin
         n_checks++;
         if (rsp_data !== 8'h00 || rsp_err !== 1'b1 || rsp_id !== 2'd2) begin
            n_errors++;
            $display("FAIL illegal_op: data=%h err=%b id=%0d, required 00 1 2", rsp_data, rsp_err, rsp_id);
         end
      end
      drain();
      tick();
      set_req(3, 3'd4, 8'h5A, 8'h3C, 8'h0F);
      exp3 = {1'b0, 8'h5A ^ 8'h3C ^ 8'h0F};
      req_valid = 4'b1000;
      wait_grant(3, ok);
      tick();
      req_valid = '0;
      wait_rsp(ok);
      if (ok) begin
         n_checks++;
         if (rsp_err !== 1'b0 || rsp_id !== 2'd3 || {rsp_err, rsp_data} !== exp3) begin
            n_errors++;
            $display("FAIL legal_after_illegal: err=%b id=%0d data=%h, required 0 3 %h",
                     rsp_err, rsp_id, rsp_data, exp3[W-1:0]);
         end
      end
      drain();
   endtask

   task automatic test_wrap();
      bit ok;
      // last grant was requester 3
      tick();
      set_rand(0);
      set_rand(1);
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_errors++;
         $display("FAIL wrap_after3: req_ready=%b, required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      drain();
      // put ptr at 3 via a lone grant to requester 2
      tick();
      set_rand(2);
      req_valid = 4'b0100;
      wait_grant(2, ok);
      tick();
      req_valid = '0;
      drain();
      tick();
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_errors++;
         $display("FAIL wrap_ptr3: req_ready=%b, required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      drain();
      // requester 1 kept its place after being skipped
      tick();
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_errors++;
         $display("FAIL skipped_keeps_turn: req_ready=%b, required 0010", req_ready);
      end
      tick();
      req_valid = '0;
      drain();
   endtask

   task automatic test_reset_mid();
      bit ok;
      tick();
      set_rand(1);
      set_rand(3);
      req_valid = 4'b0010;
      wait_grant(1, ok);
      tick();                       // now in EVAL
      rst_n     = 1'b0;
      req_valid = 4'b1010;
      exp_q.delete();
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, state_dbg} !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_outputs: ready=%b valid=%b id=%0d data=%h err=%b state=%0d, required all 0",
                  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, state_dbg);
      end
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_hold: valid=%b ready=%b, required 0 0000", rsp_valid, req_ready);
         end
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_errors++;
         $display("FAIL reset_first_grant: req_ready=%b, required 0010", req_ready);
      end
      tick();
      req_valid = 4'b1000;
      wait_grant(3, ok);
      tick();
      req_valid = '0;
      drain();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_round_robin();
      test_ops();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_reset_mid();
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL final_queue: %0d expected responses left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
